// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the single-port data memory.
// Port 0 (core LSU) is favoured. Port 1 (debug/DMA) is forced through after MAX_BURST
// consecutive port 0 grants while it waits.
// Each granted request is latched, drives the memory for one cycle, and returns a
// registered response one cycle later. A new grant can be issued every cycle.
// Optional feature: define DMEM_ALIGN_CHK_EN to flag misaligned or invalid-size accesses
// with pN_err. Those accesses never write memory.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_size,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_size,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        m_we,
    output logic [2:0]  m_op_size,
    output logic [31:0] m_a,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic             state;
    logic [CNT_W-1:0] burst_cnt;
    logic             force_p1;
    logic             any_gnt;

    logic             sel_we;
    logic [2:0]       sel_size;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_err;
    logic             sel_sup;

    logic             lat_id;
    logic             lat_we;
    logic [2:0]       lat_size;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic             lat_err;
    logic             lat_sup;

    logic             resp_valid;
    logic             resp_id;
    logic [31:0]      resp_rdata;
    logic             resp_err;

    // Stores accept only b/h/w. Loads reject the three unused codes.
    function automatic logic size_invalid(input logic we, input logic [2:0] size);
        if (we)
            return !(size == 3'b000 || size == 3'b001 || size == 3'b010);
        else
            return (size == 3'b011 || size == 3'b110 || size == 3'b111);
    endfunction

`ifdef DMEM_ALIGN_CHK_EN
    function automatic logic misaligned(input logic [2:0] size, input logic [31:0] addr);
        return ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
               ((size[1:0] == 2'b01) && addr[0]);
    endfunction
`endif

    // Port 0 wins unless port 1 has already waited through a full burst.
    assign force_p1 = (burst_cnt == CNT_W'(MAX_BURST));
    assign p0_gnt   = p0_req & ~(p1_req & force_p1);
    assign p1_gnt   = p1_req & ~p0_gnt;
    assign any_gnt  = p0_gnt | p1_gnt;

    // Select the winning payload and classify it before it is latched.
    always_comb begin
        sel_we    = p0_we;
        sel_size  = p0_size;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (p1_gnt) begin
            sel_we    = p1_we;
            sel_size  = p1_size;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
`ifdef DMEM_ALIGN_CHK_EN
        sel_err = size_invalid(sel_we, sel_size) | misaligned(sel_size, sel_addr);
`else
        sel_err = 1'b0;
`endif
        sel_sup = size_invalid(sel_we, sel_size) | sel_err;
    end

    // Track consecutive port 0 wins while port 1 is waiting. The count saturates at MAX_BURST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            burst_cnt <= '0;
        else if (!p1_req || p1_gnt)
            burst_cnt <= '0;
        else if (p0_gnt && !force_p1)
            burst_cnt <= burst_cnt + 1'b1;
    end

    // Latch the handshaken op. The latched fields hold while idle, so m_* keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= 3'b000;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_err   <= 1'b0;
            lat_sup   <= 1'b0;
        end else begin
            state <= any_gnt ? BUSY : IDLE;
            if (any_gnt) begin
                lat_id    <= p1_gnt;
                lat_we    <= sel_we;
                lat_size  <= sel_size;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_err   <= sel_err;
                lat_sup   <= sel_sup;
            end
        end
    end

    assign m_we      = (state == BUSY) & lat_we & ~lat_sup;
    assign m_op_size = lat_size;
    assign m_a       = lat_addr;
    assign m_wd      = lat_wdata;

    // Capture the memory result at the same edge that commits a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= (state == BUSY);
            if (state == BUSY) begin
                resp_id    <= lat_id;
                resp_rdata <= (lat_we | lat_sup) ? 32'h0 : m_rd;
                resp_err   <= lat_err;
            end
        end
    end

    assign p0_rvalid = resp_valid & ~resp_id;
    assign p1_rvalid = resp_valid & resp_id;
    assign p0_rdata  = p0_rvalid ? resp_rdata : 32'h0;
    assign p1_rdata  = p1_rvalid ? resp_rdata : 32'h0;
    assign p0_err    = p0_rvalid & resp_err;
    assign p1_err    = p1_rvalid & resp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a small byte-addressed memory model.
// Expected responses are queued when a request is granted. A monitor pops and compares them
// whenever a port returns rvalid. Follows DMEM_ALIGN_CHK_EN when it is defined.
module tb_dmem_arbiter;

`ifdef DMEM_ALIGN_CHK_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [2:0]  p0_size;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [2:0]  p1_size;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        m_we;
    logic [2:0]  m_op_size;
    logic [31:0] m_a, m_wd, m_rd;

    logic [7:0]  mem [0:255];
    logic        memInit;
    logic        weWatch;
    int          weHighCount;
    int          checks;
    int          errors;
    resp_t       q0[$];
    resp_t       q1[$];

    dmem_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .m_we(m_we), .m_op_size(m_op_size), .m_a(m_a), .m_wd(m_wd), .m_rd(m_rd)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read extended per size code, write on the clock edge.
    always_comb begin
        logic [7:0] a;
        m_rd = 32'h0;
        a = m_a[7:0];
        case (m_op_size)
            3'b000: m_rd = {{24{mem[a][7]}}, mem[a]};
            3'b100: m_rd = {24'h0, mem[a]};
            3'b001: m_rd = {{16{mem[{a[7:1], 1'b1}][7]}}, mem[{a[7:1], 1'b1}], mem[{a[7:1], 1'b0}]};
            3'b101: m_rd = {16'h0, mem[{a[7:1], 1'b1}], mem[{a[7:1], 1'b0}]};
            3'b010: m_rd = {mem[{a[7:2], 2'b11}], mem[{a[7:2], 2'b10}],
                            mem[{a[7:2], 2'b01}], mem[{a[7:2], 2'b00}]};
            default: m_rd = 32'h0;
        endcase
    end

    // Clear the memory at start-up, then apply committed stores.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (m_we) begin
            case (m_op_size)
                3'b000: mem[m_a[7:0]] <= m_wd[7:0];
                3'b001: begin
                    mem[{m_a[7:1], 1'b0}] <= m_wd[7:0];
                    mem[{m_a[7:1], 1'b1}] <= m_wd[15:8];
                end
                3'b010: begin
                    mem[{m_a[7:2], 2'b00}] <= m_wd[7:0];
                    mem[{m_a[7:2], 2'b01}] <= m_wd[15:8];
                    mem[{m_a[7:2], 2'b10}] <= m_wd[23:16];
                    mem[{m_a[7:2], 2'b11}] <= m_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: every rvalid must match the oldest expectation for that port.
    always @(negedge clk) begin
        resp_t e;
        if (!rst) begin
            if (p0_rvalid && p1_rvalid) begin
                checks++;
                errors++;
                $display("[TB] FAIL dual_rvalid: got both ports valid, expected one at %0t", $time);
            end
            if (p0_rvalid) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL p0_unexpected_rvalid: got rvalid=1, expected 0 at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    checkOutput("p0_rdata", p0_rdata, e.rdata);
                    checkOutput("p0_err", {31'h0, p0_err}, {31'h0, e.err});
                end
            end
            if (p1_rvalid) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL p1_unexpected_rvalid: got rvalid=1, expected 0 at %0t", $time);
                end else begin
                    e = q1.pop_front();
                    checkOutput("p1_rdata", p1_rdata, e.rdata);
                    checkOutput("p1_err", {31'h0, p1_err}, {31'h0, e.err});
                end
            end
        end
        if (weWatch && m_we) weHighCount++;
    end

    // Present one request, wait (bounded) for its grant, and queue the expected response.
    // Returns 1ns after the handshake edge with req still high.
    task automatic applyStimulus(input int port, input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input bit push);
        bit done;
        done = 1'b0;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
        end
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if ((port == 0) ? p0_gnt : p1_gnt) begin
                if (push) begin
                    if (port == 0) q0.push_back('{expRdata, expErr});
                    else           q1.push_back('{expRdata, expErr});
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: got no grant on port %0d, expected grant", port);
        end
    endtask

    initial begin
        logic [9:0] expP1;
        checks = 0; errors = 0; weWatch = 1'b0; weHighCount = 0;
        rst = 1'b1; memInit = 1'b1;
        p0_req = 0; p0_we = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        memInit = 1'b0;
        checkOutput("reset_p0_rvalid", {31'h0, p0_rvalid}, 32'h0);
        checkOutput("reset_p1_rvalid", {31'h0, p1_rvalid}, 32'h0);
        checkOutput("reset_m_we", {31'h0, m_we}, 32'h0);
        checkOutput("reset_m_a", m_a, 32'h0);
        checkOutput("reset_m_op_size", {29'h0, m_op_size}, 32'h0);
        checkOutput("reset_m_wd", m_wd, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Store then load to the same word, back to back.
        applyStimulus(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        p0_req = 1'b0;
        checkOutput("t1_store_rvalid_T2", {31'h0, p0_rvalid}, 32'h1);
        repeat (3) @(posedge clk); #1;

        // Port 1 byte store, followed by signed and unsigned byte loads and a word readback.
        applyStimulus(1, 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b1);
        p1_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Pipelined loads on port 0. No memory write may occur.
        weWatch = 1'b1;
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFA5AD, 1'b0, 1'b1);
        p0_req = 1'b0;
        checkOutput("t4_rvalid_T2", {31'h0, p0_rvalid}, 32'h1);
        repeat (3) @(posedge clk); #1;
        weWatch = 1'b0;
        checkOutput("t4_m_we_never_high", weHighCount, 32'h0);

        // Both ports request continuously. Port 1 is forced through after four port 0 grants.
        expP1 = 10'b10_0001_0000;
        p0_req = 1'b1; p0_we = 1'b0; p0_size = 3'b010; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b0; p1_size = 3'b101; p1_addr = 32'h12;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("t3_gnt_%0d", i), {30'h0, p1_gnt, p0_gnt},
                        {30'h0, expP1[i], ~expP1[i]});
            if (expP1[i]) q1.push_back('{32'h0000A5AD, 1'b0});
            else          q0.push_back('{32'hA5ADBEEF, 1'b0});
            @(posedge clk); #1;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset during the memory cycle of a store: the store and its response are both lost.
        applyStimulus(0, 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
        p0_req = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("t5_m_we_in_reset", {31'h0, m_we}, 32'h0);
        checkOutput("t5_m_a_in_reset", m_a, 32'h0);
        @(posedge clk); #1;
        checkOutput("t5_no_rvalid", {31'h0, p0_rvalid}, 32'h0);
        rst = 1'b0;
        checkOutput("t5_mem_untouched", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
        p0_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Misaligned word store: flagged and suppressed when checking is on, raw write otherwise.
        applyStimulus(0, 1'b1, 3'b010, 32'h12, 32'hCAFEF00D, 32'h0, ALIGN, 1'b1);
        p0_req = 1'b0;
        checkOutput("t6_m_we_misaligned", {31'h0, m_we}, {31'h0, ~ALIGN});
        repeat (2) @(posedge clk); #1;
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, ALIGN ? 32'hA5ADBEEF : 32'hCAFEF00D, 1'b0, 1'b1);
        // Invalid load size returns zero data. Invalid store size never writes.
        applyStimulus(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, ALIGN, 1'b1);
        applyStimulus(0, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, ALIGN, 1'b1);
        p0_req = 1'b0;
        checkOutput("t6_m_we_bad_store_size", {31'h0, m_we}, 32'h0);
        repeat (2) @(posedge clk); #1;
        applyStimulus(0, 1'b0, 3'b010, 32'h10, 32'h0, ALIGN ? 32'hA5ADBEEF : 32'hCAFEF00D, 1'b0, 1'b1);
        p0_req = 1'b0;
        repeat (5) @(posedge clk); #1;

        checkOutput("drain_q0", q0.size(), 32'h0);
        checkOutput("drain_q1", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus process stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
